// File: rtl/md_pkg.sv
// md_pkg: op codes, FSM states and op classification for md_unit (MDU_MADD_EN enables MADD/MSUB family).
package md_pkg;
  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] OP_MADD  = 4'd7;
  localparam logic [OP_W-1:0] OP_MADDU = 4'd8;
  localparam logic [OP_W-1:0] OP_MSUB  = 4'd9;
  localparam logic [OP_W-1:0] OP_MSUBU = 4'd10;
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
  function automatic logic is_div(input logic [OP_W-1:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
  function automatic logic is_mul(input logic [OP_W-1:0] op);
`ifdef MDU_MADD_EN
    return op == OP_MULT || op == OP_MULTU || op == OP_MADD || op == OP_MADDU ||
           op == OP_MSUB || op == OP_MSUBU;
`else
    return op == OP_MULT || op == OP_MULTU;
`endif
  endfunction
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return is_mul(op) || is_div(op);
  endfunction
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational multiply/divide/accumulate datapath (accumulate only with MDU_MADD_EN).
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int W2 = 2 * WIDTH;
  logic sgn, rs_neg, rt_neg, dz;
  logic [W2-1:0] prod, base;
  logic [WIDTH-1:0] a, b, bd, q, r, quot, rem;
  assign sgn = op == OP_DIV || op == OP_MULT || op == OP_MADD || op == OP_MSUB;
  assign rs_neg = sgn & rs[WIDTH-1];
  assign rt_neg = sgn & rt[WIDTH-1];
  // one shared multiplier: sign-extending the operands makes the low 2*WIDTH bits the signed product
  assign prod = {{WIDTH{rs_neg}}, rs} * {{WIDTH{rt_neg}}, rt};
  // magnitude division; MIN/-1 naturally yields quotient MIN, remainder 0
  assign a = rs_neg ? -rs : rs;
  assign b = rt_neg ? -rt : rt;
  assign dz = rt == '0;
  assign bd = dz ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign q = a / bd;
  assign r = a % bd;
  assign quot = rs_neg ^ rt_neg ? -q : q;
  assign rem = rs_neg ? -r : r;
`ifdef MDU_MADD_EN
  logic [W2-1:0] acc;
  assign acc = op == OP_MSUB || op == OP_MSUBU ? {hi, lo} - prod : {hi, lo} + prod;
  assign base = op == OP_MADD || op == OP_MADDU || op == OP_MSUB || op == OP_MSUBU ? acc : {hi, lo};
`else
  assign base = {hi, lo};
`endif
  assign {res_hi, res_lo} = op == OP_MULT || op == OP_MULTU ? prod :
                            is_div(op) ? (dz ? {rs, {WIDTH{1'b1}}} : {rem, quot}) : base;
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle hi/lo multiply/divide unit with flush suppression; MDU_MADD_EN adds MADD/MSUB family.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] res_hi, res_lo, c_hi, c_lo;
  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op(op), .rs(rs), .rt(rt), .hi(hi), .lo(lo), .res_hi(c_hi), .res_lo(c_lo)
  );
  assign start = op_valid & is_muldiv(op) & ~flush & ~busy;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      busy <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      res_hi <= '0;
      res_lo <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        res_hi <= c_hi;
        res_lo <= c_lo;
        cnt <= is_div(op) ? CW'(DIV_LAT) : CW'(MUL_LAT);
        state <= ST_BUSY;
        busy <= 1'b1;
      end else if (op_valid && !flush) begin
        if (op == OP_MTHI) hi <= rs;
        if (op == OP_MTLO) lo <= rs;
      end
    end else begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        hi <= res_hi;
        lo <= res_lo;
        state <= ST_IDLE;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table-driven check of md_unit plus flush, busy-ignore and reset-mid-op sequences.
module tb_md_unit;
  import md_pkg::*;
  logic clk = 1'b0, reset = 1'b1, op_valid = 1'b0, flush = 1'b0;
  logic [3:0] op = '0;
  logic [31:0] rs = '0, rt = '0;
  logic start, busy;
  logic [31:0] hi, lo;
  int n_chk = 0, n_fail = 0;

  md_unit dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rs(rs), .rt(rt),
    .flush(flush), .start(start), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic [3:0] op;
    logic [31:0] rs, rt, hi, lo;
    int lat;
  } vec_t;
  vec_t v[16];

  function automatic vec_t mk(input string nm, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] h, input logic [31:0] l, input int lt);
    vec_t x;
    x.name = nm; x.op = o; x.rs = a; x.rt = b; x.hi = h; x.lo = l; x.lat = lt;
    return x;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after busy has dropped
  task automatic run(input vec_t x, input logic [31:0] old_hi, input logic [31:0] old_lo);
    int n;
    op_valid = 1'b1; op = x.op; rs = x.rs; rt = x.rt;
    #1 check({x.name, " start"}, 64'(start), 64'(x.lat != 0));
    @(posedge clk);
    #1 op_valid = 1'b0; op = OP_NONE;
    @(negedge clk);
    n = 0;
    while (busy && n < 40) begin
      if (n == 0) check({x.name, " hold"}, {hi, lo}, {old_hi, old_lo});
      n++;
      @(negedge clk);
    end
    check({x.name, " busy_cycles"}, 64'(n), 64'(x.lat));
    check({x.name, " hi"}, 64'(hi), 64'(x.hi));
    check({x.name, " lo"}, 64'(lo), 64'(x.lo));
  endtask

  initial begin
    int n;
    v[0]  = mk("mult",      OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    v[1]  = mk("multu",     OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5);
    v[2]  = mk("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    v[3]  = mk("divu_zero", OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 10);
    v[4]  = mk("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10);
    v[5]  = mk("divu",      OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10);
    v[6]  = mk("div_negd",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10);
    v[7]  = mk("div_zero",  OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 10);
    v[8]  = mk("mult_min",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        5);
    v[9]  = mk("mthi",      OP_MTHI,  32'h0000DEAD, 32'd0,        32'h0000DEAD, 32'd0,        0);
    v[10] = mk("mtlo",      OP_MTLO,  32'h0000BEEF, 32'd0,        32'h0000DEAD, 32'h0000BEEF, 0);
    v[11] = mk("none",      OP_NONE,  32'd1,        32'd1,        32'h0000DEAD, 32'h0000BEEF, 0);
    v[12] = mk("unknown",   4'd15,    32'd1,        32'd1,        32'h0000DEAD, 32'h0000BEEF, 0);
    v[13] = mk("mthi0",     OP_MTHI,  32'd0,        32'd0,        32'd0,        32'h0000BEEF, 0);
    v[14] = mk("mtlo1",     OP_MTLO,  32'd1,        32'd0,        32'd0,        32'd1,        0);
`ifdef MDU_MADD_EN
    v[15] = mk("madd",      OP_MADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd2,        5);
`else
    v[15] = mk("madd_off",  OP_MADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        0);
`endif
    repeat (2) @(negedge clk);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) run(v[i], i == 0 ? 32'd0 : v[i-1].hi, i == 0 ? 32'd0 : v[i-1].lo);
`ifdef MDU_MADD_EN
    run(mk("msubu", OP_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd1, 5), 32'd0, 32'd2);
`else
    run(mk("msubu_off", OP_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 0), 32'd0, 32'd1);
`endif
    // flush in the accept cycle suppresses the op
    op_valid = 1'b1; op = OP_MULT; rs = 32'd9; rt = 32'd9; flush = 1'b1;
    #1 check("flush start", 64'(start), 64'd0);
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
`ifdef MDU_MADD_EN
    check("flush hilo", {hi, lo}, {32'd2, 32'd1});
`else
    check("flush hilo", {hi, lo}, {32'd0, 32'd1});
`endif
    // MTHI while busy is ignored
    op_valid = 1'b1; op = OP_MULT; rs = 32'd3; rt = 32'd4;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (2) @(negedge clk);
    op_valid = 1'b1; op = OP_MTHI; rs = 32'h1234; flush = 1'b0;
    #1 check("mthi_busy start", 64'(start), 64'd0);
    @(negedge clk);
    op_valid = 1'b0; op = OP_NONE;
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    check("mthi_busy drained", 64'(busy), 64'd0);
    check("mthi_busy hilo", {hi, lo}, {32'd0, 32'd12});
    // reset in busy cycle 3 of a divide
    op_valid = 1'b1; op = OP_DIV; rs = 32'd100; rt = 32'd7;
    @(posedge clk);
    #1 op_valid = 1'b0; op = OP_NONE;
    repeat (3) @(negedge clk);
    check("rst_mid busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1 check("rst_mid busy", 64'(busy), 64'd0);
    check("rst_mid hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_mid no_commit", {hi, lo}, 64'd0);
    check("rst_mid idle", 64'(busy), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit for the EX stage of the pipelined MIPS core. It generalises the existing hi/lo unit with configurable operand width and per-operation latency, and defines division-by-zero and overflow results. It also supports suppressing an operation when a CP0 exception or interrupt flush is raised in the accept cycle. It drives `start`/`busy` to the hazard unit, which stalls mult/div/mfhi/mflo/mthi/mtlo while the unit is occupied.

## Interface
- `WIDTH`, 32: operand and hi/lo width.
- `MUL_LAT`, 5: busy cycles for MULT/MULTU (and MADD/MSUB family); must be ≥1.
- `DIV_LAT`, 10: busy cycles for DIV/DIVU; must be ≥1.

- `clk`  in  1  single clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `op_valid`  in  1  an EX-stage instruction presents `op` this cycle.
- `op`  in  4  operation code, `md_pkg::OP_*`.
- `rs`  in  WIDTH  forwarded rs operand.
- `rt`  in  WIDTH  forwarded rt operand.
- `flush`  in  1  exception, interrupt or eret in M stage; kills the EX instruction.
- `start`  out  1  combinational; the operation is accepted this cycle.
- `busy`  out  1  registered; an operation is in flight.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- **States:** IDLE and BUSY. Supporting registers are a countdown counter `cnt` of width clog2(max(MUL_LAT, DIV_LAT)+1) and the pending results `res_hi`/`res_lo`.
- **start** = `op_valid & is_muldiv(op) & ~flush & ~busy`.
- **IDLE → BUSY on `start`:**
  - compute the result from `rs`/`rt` and capture it in `res_hi`/`res_lo`;
  - load `cnt` with MUL_LAT or DIV_LAT.
- **BUSY:**
  - `cnt` decrements each cycle.
  - When `cnt == 1`, commit `hi<=res_hi`, `lo<=res_lo` and go to IDLE.
- **MTHI / MTLO:** when `op_valid & ~flush & ~busy`, write `hi` / `lo` at the next edge. They do not assert `busy` or `start`.
- **Ignored inputs:**
  - Any `op_valid` while `busy` is ignored; upstream stalls guarantee this does not occur.
  - `OP_NONE` and unknown codes are no-ops.
- **flush:**
  - In the accept cycle, `flush` suppresses the operation entirely: no state change.
  - While BUSY, `flush` has no effect. The in-flight operation belongs to an older instruction and completes.
- **Multiplication:**
  - MULT: signed product of width 2·WIDTH, giving {hi,lo}.
  - MULTU: unsigned product of width 2·WIDTH, giving {hi,lo}.
- **Division:**
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Divide by zero: lo = all ones, hi = `rs`.
  - Signed overflow (MIN / −1): lo = MIN, hi = 0.
- **Reset:** `hi = 0`, `lo = 0`, `busy = 0`, `cnt = 0`, state IDLE. A reset mid-operation discards the pending result permanently.

## Timing
- Accept at edge E0 → `busy` = 1 from E0 through edge E(LAT)−1.
- `hi`/`lo` are updated at edge E(LAT), and `busy` falls at that same edge.
- Net: `busy` is high for exactly LAT cycles, and new `hi`/`lo` are visible in the cycle after the last busy cycle.
- `hi`/`lo` hold their old values throughout BUSY.
- MTHI/MTLO take effect one edge after the request.
- A back-to-back operation is accepted in the first cycle with `busy` = 0.
- `start` has zero latency; the hazard unit uses `start | busy`.

## Configuration
- **`MDU_MADD_EN` defined:** OP_MADD, OP_MADDU, OP_MSUB and OP_MSUBU are enabled.
  - They compute {hi,lo} ± rs·rt, signed or unsigned respectively, modulo 2^(2·WIDTH).
  - The accumulation base is {hi,lo} sampled at accept.
  - They use MUL_LAT.
- **`MDU_MADD_EN` undefined:**
  - These four codes are treated as unknown: no start, no busy, `hi`/`lo` unchanged.
  - No accumulation adder is synthesised.

## Structure
- Package `md_pkg` holds:
  - `OP_W = 4`;
  - op codes `OP_NONE=0`, `OP_MULT=1`, `OP_MULTU=2`, `OP_DIV=3`, `OP_DIVU=4`, `OP_MTHI=5`, `OP_MTLO=6`, `OP_MADD=7`, `OP_MADDU=8`, `OP_MSUB=9`, `OP_MSUBU=10`;
  - the state encoding `ST_IDLE` / `ST_BUSY`.
- One sub-module, `md_calc`: combinational, parametrised by WIDTH.
  - Inputs: `op`, `rs`, `rt`, `hi`, `lo`.
  - Outputs: `res_hi`, `res_lo`.
  - It contains all arithmetic, including the division corner cases.
- `md_unit` contains only the FSM, counter and registers.

## Test plan
Defaults: WIDTH=32, MUL_LAT=5, DIV_LAT=10.
- **Multiply:**
  - MULT rs=0xFFFFFFFE, rt=3 → `busy` high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- **Signed divide:** DIV rs=0xFFFFFFF9 (−7), rt=2 → `busy` high for exactly 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **Divide corner cases:**
  - DIVU rs=5, rt=0 → lo=0xFFFFFFFF, hi=5.
  - DIV rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- **Flush and ignored ops:**
  - MULT with `flush`=1 in the same cycle → `start`=0, `busy` stays 0, `hi`/`lo` unchanged.
  - MTHI 0x1234 issued while `busy` → ignored; hi equals the mult result.
- **Reset mid-operation:** assert `reset` in busy cycle 3 of a DIV → hi=lo=0 and `busy`=0 immediately; no commit occurs afterwards.
- **`MDU_MADD_EN`:**
  - With {hi,lo}={0,1}, MADD rs=rt=0xFFFFFFFF → after 5 cycles hi=0, lo=2.
  - Build without the macro and repeat: `start`=0, `busy`=0, `hi`/`lo` unchanged.
